// File: rtl/avalon_protocol_monitor_if.sv
// Avalon-MM bus bundle seen by avalon_protocol_monitor; master/slave views plus
// a passive all-input view for the monitor.
interface avalon_protocol_monitor_if #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8
);
  logic [NBADDRBITS-1:0]    address;
  logic [NBDATABYTES-1:0]   byteenable;
  logic [8*NBDATABYTES-1:0] readdata;
  logic [8*NBDATABYTES-1:0] writedata;
  logic                     read;
  logic                     write;
  logic                     waitrequest;
  logic                     readdatavalid;
  logic [7:0]               burstcount;
  logic                     beginbursttransfer;

  modport master (
    output address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    output readdata, waitrequest, readdatavalid
  );

  modport monitor (
    input address, byteenable, readdata, writedata, read, write, waitrequest,
          readdatavalid, burstcount, beginbursttransfer
  );
endinterface

// File: rtl/avalon_protocol_monitor.sv
// Passive Avalon-MM slave-side protocol checker: sticky/pulsed error bits,
// first-error capture and saturating traffic counters for all AVALONMODE flavours.
module avalon_protocol_monitor #(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WRITEDELAY  = 2,
  parameter int READDELAY   = 1,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 8,
  parameter int MAXBURST    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  avalon_protocol_monitor_if.monitor bus,
  input  logic                       err_clear,
  output logic [7:0]                 err_flags,
  output logic [7:0]                 err_pulse,
  output logic [2:0]                 first_err,
  output logic                       first_err_valid,
  output logic [7:0]                 pending_cnt,
  output logic [15:0]                nb_read_cmd,
  output logic [15:0]                nb_write_cmd,
  output logic [15:0]                nb_rdv
);

  localparam bit M_FIXWAIT  = (AVALONMODE == 1);
  localparam bit M_STALLCHK = (AVALONMODE != 1);
  localparam bit M_PEND     = (AVALONMODE >= 2);
  localparam bit M_FIXLAT   = (AVALONMODE == 3);
  localparam bit M_BURST    = (AVALONMODE == 4);

  typedef enum logic {BST_IDLE, BST_WBURST} bst_e;

  bst_e                     bst_q, bst_d;
  logic [7:0]               remain_q, remain_d;
  logic [7:0]               bbc_q, bbc_d;
  logic [NBADDRBITS-1:0]    baddr_q, baddr_d;

  logic                     stall_q, stall_d;
  logic [NBADDRBITS-1:0]    paddr_q, paddr_d;
  logic [NBDATABYTES-1:0]   pbe_q, pbe_d;
  logic                     prd_q, prd_d;
  logic                     pwr_q, pwr_d;
  logic [7:0]               pbc_q, pbc_d;
  logic [8*NBDATABYTES-1:0] pwd_q, pwd_d;

  logic [3:0]               rhold_q, rhold_d;
  logic [3:0]               whold_q, whold_d;
  logic [FIXEDDELAY-1:0]    lat_q, lat_d;

  logic [7:0]               err_flags_q, err_flags_d;
  logic [7:0]               err_pulse_q, err_pulse_d;
  logic [2:0]               first_err_q, first_err_d;
  logic                     fev_q, fev_d;
  logic [7:0]               pending_q, pending_d;
  logic [15:0]              nb_rd_q, nb_rd_d;
  logic [15:0]              nb_wr_q, nb_wr_d;
  logic [15:0]              nb_rdv_q, nb_rdv_d;

  logic                     req, rd_acc, wr_acc, first_beat, bad_bc, found;
  logic [7:0]               inc, err_now;
  logic [9:0]               sum;
  logic [2:0]               lowest;
  logic                     unused_readdata;

  assign unused_readdata = ^bus.readdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    req = bus.read | bus.write;
    if (M_FIXWAIT) begin
      rd_acc = bus.read  && (rhold_q == 4'(READDELAY - 1));
      wr_acc = bus.write && (whold_q == 4'(WRITEDELAY - 1));
    end else begin
      rd_acc = bus.read  && !bus.waitrequest;
      wr_acc = bus.write && !bus.waitrequest;
    end

    // Hold counters restart after the accepting cycle so a held strobe is back-to-back transfers
    rhold_d = '0;
    whold_d = '0;
    if (M_FIXWAIT && bus.read && !rd_acc)   rhold_d = rhold_q + 4'd1;
    if (M_FIXWAIT && bus.write && !wr_acc)  whold_d = whold_q + 4'd1;

    stall_d = M_STALLCHK && req && bus.waitrequest;
    paddr_d = bus.address;
    pbe_d   = bus.byteenable;
    prd_d   = bus.read;
    pwr_d   = bus.write;
    pbc_d   = bus.burstcount;
    pwd_d   = bus.writedata;

    inc = '0;
    if (M_PEND && rd_acc) inc = M_BURST ? bus.burstcount : 8'd1;
    sum = 10'(pending_q) + 10'(inc);
    err_now = '0;
    err_now[2] = M_PEND && bus.readdatavalid && (sum == 10'd0);
    if (M_PEND && bus.readdatavalid && sum != 10'd0) sum = sum - 10'd1;
    err_now[3] = M_PEND && rd_acc && (sum > 10'(MAXPENDING));
    pending_d = '0;
    if (M_PEND) pending_d = (sum > 10'd255) ? 8'hFF : sum[7:0];

    lat_d = '0;
    if (M_FIXLAT) begin
      lat_d[0] = rd_acc;
      for (int unsigned i = 1; i < FIXEDDELAY; i++) lat_d[i] = lat_q[i-1];
    end
    err_now[4] = M_FIXLAT && (lat_q[FIXEDDELAY-1] != bus.readdatavalid);

    err_now[0] = bus.read & bus.write;
    err_now[1] = M_STALLCHK && stall_q &&
                 ((bus.address != paddr_q) || (bus.byteenable != pbe_q) ||
                  (bus.read != prd_q) || (bus.write != pwr_q) ||
                  (bus.burstcount != pbc_q) || (pwr_q && bus.writedata != pwd_q));

    first_beat = rd_acc || (wr_acc && bst_q == BST_IDLE);
    bad_bc     = (bus.burstcount == 8'd0) || (bus.burstcount > 8'(MAXBURST));
    err_now[5] = M_BURST &&
                 ((first_beat && bad_bc) ||
                  (bus.beginbursttransfer && !req) ||
                  (bus.read && bst_q == BST_WBURST) ||
                  (bst_q == BST_WBURST && wr_acc &&
                   (bus.burstcount != bbc_q || bus.address != baddr_q)));

    err_now[7] = M_FIXWAIT && ((!bus.read && rhold_q != 4'd0) ||
                               (!bus.write && whold_q != 4'd0));

    bst_d    = bst_q;
    remain_d = remain_q;
    bbc_d    = bbc_q;
    baddr_d  = baddr_q;
    if (err_clear || !M_BURST) begin
      bst_d = BST_IDLE;
    end else begin
      case (bst_q)
        BST_IDLE: if (wr_acc && bus.burstcount > 8'd1) begin
          bst_d    = BST_WBURST;
          remain_d = bus.burstcount - 8'd1;
          bbc_d    = bus.burstcount;
          baddr_d  = bus.address;
        end
        BST_WBURST: if (wr_acc) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) bst_d = BST_IDLE;
        end
        default: bst_d = BST_IDLE;
      endcase
    end

    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (err_now[i] && !found) begin
        lowest = 3'(i);
        found  = 1'b1;
      end
    end

    // Clear wins over a same-cycle detection; the pulse itself is still reported
    err_pulse_d = err_now;
    err_flags_d = err_clear ? '0 : (err_flags_q | err_now);
    first_err_d = first_err_q;
    fev_d       = fev_q;
    if (err_clear) begin
      first_err_d = '0;
      fev_d       = 1'b0;
    end else if (!fev_q && found) begin
      first_err_d = lowest;
      fev_d       = 1'b1;
    end

    nb_rd_d  = err_clear ? '0 : sat_inc(nb_rd_q, rd_acc);
    nb_wr_d  = err_clear ? '0 : sat_inc(nb_wr_q, wr_acc);
    nb_rdv_d = err_clear ? '0 : sat_inc(nb_rdv_q, bus.readdatavalid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bst_q       <= BST_IDLE;
      remain_q    <= '0;
      bbc_q       <= '0;
      baddr_q     <= '0;
      stall_q     <= 1'b0;
      paddr_q     <= '0;
      pbe_q       <= '0;
      prd_q       <= 1'b0;
      pwr_q       <= 1'b0;
      pbc_q       <= '0;
      pwd_q       <= '0;
      rhold_q     <= '0;
      whold_q     <= '0;
      lat_q       <= '0;
      err_flags_q <= '0;
      err_pulse_q <= '0;
      first_err_q <= '0;
      fev_q       <= 1'b0;
      pending_q   <= '0;
      nb_rd_q     <= '0;
      nb_wr_q     <= '0;
      nb_rdv_q    <= '0;
    end else begin
      bst_q       <= bst_d;
      remain_q    <= remain_d;
      bbc_q       <= bbc_d;
      baddr_q     <= baddr_d;
      stall_q     <= stall_d;
      paddr_q     <= paddr_d;
      pbe_q       <= pbe_d;
      prd_q       <= prd_d;
      pwr_q       <= pwr_d;
      pbc_q       <= pbc_d;
      pwd_q       <= pwd_d;
      rhold_q     <= rhold_d;
      whold_q     <= whold_d;
      lat_q       <= lat_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      first_err_q <= first_err_d;
      fev_q       <= fev_d;
      pending_q   <= pending_d;
      nb_rd_q     <= nb_rd_d;
      nb_wr_q     <= nb_wr_d;
      nb_rdv_q    <= nb_rdv_d;
    end
  end

  assign err_flags       = err_flags_q;
  assign err_pulse       = err_pulse_q;
  assign first_err       = first_err_q;
  assign first_err_valid = fev_q;
  assign pending_cnt     = pending_q;
  assign nb_read_cmd     = nb_rd_q;
  assign nb_write_cmd    = nb_wr_q;
  assign nb_rdv          = nb_rdv_q;

endmodule

// File: tb/tb_avalon_protocol_monitor.sv
// Directed bench: one monitor instance per AVALONMODE, sharing clock and reset.
module tb_avalon_protocol_monitor;

  logic clk;
  logic rst;
  logic clr [5];

  logic [7:0]  flags [5];
  logic [7:0]  pulse [5];
  logic [2:0]  fe    [5];
  logic        fev   [5];
  logic [7:0]  pend  [5];
  logic [15:0] nbrd  [5];
  logic [15:0] nbwr  [5];
  logic [15:0] nbrdv [5];

  int n_chk = 0;
  int n_bad = 0;

  avalon_protocol_monitor_if #(.NBDATABYTES(2), .NBADDRBITS(8)) i0 ();
  avalon_protocol_monitor_if #(.NBDATABYTES(2), .NBADDRBITS(8)) i1 ();
  avalon_protocol_monitor_if #(.NBDATABYTES(2), .NBADDRBITS(8)) i2 ();
  avalon_protocol_monitor_if #(.NBDATABYTES(2), .NBADDRBITS(8)) i3 ();
  avalon_protocol_monitor_if #(.NBDATABYTES(2), .NBADDRBITS(8)) i4 ();

  avalon_protocol_monitor #(.AVALONMODE(0)) u_m0 (
    .clk(clk), .rst(rst), .bus(i0), .err_clear(clr[0]), .err_flags(flags[0]),
    .err_pulse(pulse[0]), .first_err(fe[0]), .first_err_valid(fev[0]), .pending_cnt(pend[0]),
    .nb_read_cmd(nbrd[0]), .nb_write_cmd(nbwr[0]), .nb_rdv(nbrdv[0]));

  avalon_protocol_monitor #(.AVALONMODE(1), .READDELAY(3), .WRITEDELAY(2)) u_m1 (
    .clk(clk), .rst(rst), .bus(i1), .err_clear(clr[1]), .err_flags(flags[1]),
    .err_pulse(pulse[1]), .first_err(fe[1]), .first_err_valid(fev[1]), .pending_cnt(pend[1]),
    .nb_read_cmd(nbrd[1]), .nb_write_cmd(nbwr[1]), .nb_rdv(nbrdv[1]));

  avalon_protocol_monitor #(.AVALONMODE(2), .MAXPENDING(8)) u_m2 (
    .clk(clk), .rst(rst), .bus(i2), .err_clear(clr[2]), .err_flags(flags[2]),
    .err_pulse(pulse[2]), .first_err(fe[2]), .first_err_valid(fev[2]), .pending_cnt(pend[2]),
    .nb_read_cmd(nbrd[2]), .nb_write_cmd(nbwr[2]), .nb_rdv(nbrdv[2]));

  avalon_protocol_monitor #(.AVALONMODE(3), .FIXEDDELAY(2)) u_m3 (
    .clk(clk), .rst(rst), .bus(i3), .err_clear(clr[3]), .err_flags(flags[3]),
    .err_pulse(pulse[3]), .first_err(fe[3]), .first_err_valid(fev[3]), .pending_cnt(pend[3]),
    .nb_read_cmd(nbrd[3]), .nb_write_cmd(nbwr[3]), .nb_rdv(nbrdv[3]));

  avalon_protocol_monitor #(.AVALONMODE(4), .MAXBURST(8)) u_m4 (
    .clk(clk), .rst(rst), .bus(i4), .err_clear(clr[4]), .err_flags(flags[4]),
    .err_pulse(pulse[4]), .first_err(fe[4]), .first_err_valid(fev[4]), .pending_cnt(pend[4]),
    .nb_read_cmd(nbrd[4]), .nb_write_cmd(nbwr[4]), .nb_rdv(nbrdv[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 5; k++) clr[k] = 1'b0;
    i0.address = '0; i0.byteenable = 2'b11; i0.readdata = '0; i0.writedata = '0;
    i0.read = 0; i0.write = 0; i0.waitrequest = 0; i0.readdatavalid = 0;
    i0.burstcount = 8'd1; i0.beginbursttransfer = 0;
    i1.address = '0; i1.byteenable = 2'b11; i1.readdata = '0; i1.writedata = '0;
    i1.read = 0; i1.write = 0; i1.waitrequest = 0; i1.readdatavalid = 0;
    i1.burstcount = 8'd1; i1.beginbursttransfer = 0;
    i2.address = '0; i2.byteenable = 2'b11; i2.readdata = '0; i2.writedata = '0;
    i2.read = 0; i2.write = 0; i2.waitrequest = 0; i2.readdatavalid = 0;
    i2.burstcount = 8'd1; i2.beginbursttransfer = 0;
    i3.address = '0; i3.byteenable = 2'b11; i3.readdata = '0; i3.writedata = '0;
    i3.read = 0; i3.write = 0; i3.waitrequest = 0; i3.readdatavalid = 0;
    i3.burstcount = 8'd1; i3.beginbursttransfer = 0;
    i4.address = '0; i4.byteenable = 2'b11; i4.readdata = '0; i4.writedata = '0;
    i4.read = 0; i4.write = 0; i4.waitrequest = 0; i4.readdatavalid = 0;
    i4.burstcount = 8'd1; i4.beginbursttransfer = 0;

    tick(); tick();
    check_eq("rst_flags0", 32'(flags[0]), 32'h0);
    check_eq("rst_fev0",   32'(fev[0]),   32'h0);
    check_eq("rst_pend2",  32'(pend[2]),  32'h0);
    rst = 1'b1;
    tick();

    // Mode 0: stalled read with stable address
    i0.address = 8'h10; i0.read = 1; i0.waitrequest = 1;
    tick(); tick(); tick();
    i0.waitrequest = 0;
    tick();
    i0.read = 0;
    tick();
    check_eq("m0_ok_flags", 32'(flags[0]), 32'h0);
    check_eq("m0_ok_nbrd",  32'(nbrd[0]),  32'h1);

    // Mode 0: address changes during stall
    i0.address = 8'h10; i0.read = 1; i0.waitrequest = 1;
    tick();
    i0.address = 8'h11;
    tick();
    check_eq("m0_unst_pulse", 32'(pulse[0]), 32'h02);
    check_eq("m0_unst_fe",    32'(fe[0]),    32'h1);
    tick();
    check_eq("m0_unst_pulse_off", 32'(pulse[0]), 32'h0);
    i0.waitrequest = 0;
    tick();
    i0.read = 0;
    tick();
    check_eq("m0_unst_flags", 32'(flags[0]), 32'h02);
    check_eq("m0_unst_fev",   32'(fev[0]),   32'h1);
    check_eq("m0_unst_nbrd",  32'(nbrd[0]),  32'h2);

    // Mode 2: pending tracking and underflow
    i2.read = 1;
    tick(); check_eq("m2_pend_a", 32'(pend[2]), 32'd1);
    tick(); check_eq("m2_pend_b", 32'(pend[2]), 32'd2);
    tick(); check_eq("m2_pend_c", 32'(pend[2]), 32'd3);
    i2.read = 0; i2.readdatavalid = 1;
    tick(); check_eq("m2_pend_d", 32'(pend[2]), 32'd2);
    tick(); check_eq("m2_pend_e", 32'(pend[2]), 32'd1);
    tick(); check_eq("m2_pend_f", 32'(pend[2]), 32'd0);
    check_eq("m2_no_err", 32'(flags[2]), 32'h0);
    tick();
    check_eq("m2_under_flags", 32'(flags[2]), 32'h04);
    check_eq("m2_under_pend",  32'(pend[2]),  32'd0);
    check_eq("m2_nbrdv",       32'(nbrdv[2]), 32'd4);
    i2.readdatavalid = 0;
    tick();

    // Mode 3: correct latency then one cycle late
    i3.read = 1; tick();
    i3.read = 0; tick();
    i3.readdatavalid = 1; tick();
    i3.readdatavalid = 0; tick();
    check_eq("m3_ok_flags", 32'(flags[3]), 32'h0);
    check_eq("m3_ok_pend",  32'(pend[3]),  32'h0);
    i3.read = 1; tick();
    i3.read = 0; tick();
    tick();
    check_eq("m3_late_pulse_a", 32'(pulse[3]), 32'h10);
    i3.readdatavalid = 1; tick();
    check_eq("m3_late_pulse_b", 32'(pulse[3]), 32'h10);
    i3.readdatavalid = 0; tick();
    check_eq("m3_late_pulse_off", 32'(pulse[3]), 32'h0);
    check_eq("m3_late_flags",     32'(flags[3]), 32'h10);

    // Mode 4: clean 4-beat write burst, then a single read in idle
    i4.address = 8'h20; i4.burstcount = 8'd4; i4.write = 1;
    tick(); tick(); tick(); tick();
    i4.write = 0;
    tick();
    check_eq("m4_nbwr",     32'(nbwr[4]),  32'd4);
    check_eq("m4_ok_flags", 32'(flags[4]), 32'h0);
    i4.burstcount = 8'd1; i4.read = 1;
    tick();
    i4.read = 0;
    tick();
    check_eq("m4_idle_read", 32'(flags[4]), 32'h0);
    // burstcount above MAXBURST
    i4.burstcount = 8'd9; i4.write = 1;
    tick();
    check_eq("m4_bc9_pulse", 32'(pulse[4]), 32'h20);
    i4.write = 0; clr[4] = 1;
    tick();
    clr[4] = 0;
    check_eq("m4_clr_flags", 32'(flags[4]), 32'h0);
    // read while a write burst is open
    i4.burstcount = 8'd2; i4.write = 1;
    tick();
    i4.write = 0; i4.burstcount = 8'd1; i4.read = 1;
    tick();
    check_eq("m4_rd_open_pulse", 32'(pulse[4]), 32'h20);
    i4.read = 0;
    tick();
    check_eq("m4_rd_open_flags", 32'(flags[4]), 32'h20);

    // Mode 1: read dropped early, then a full-length hold
    i1.read = 1; tick(); tick();
    i1.read = 0; tick();
    check_eq("m1_short_flags", 32'(flags[1]), 32'h80);
    check_eq("m1_short_fe",    32'(fe[1]),    32'h7);
    i1.read = 1; tick(); tick(); tick();
    i1.read = 0; tick();
    check_eq("m1_full_pulse", 32'(pulse[1]), 32'h0);
    check_eq("m1_full_nbrd",  32'(nbrd[1]),  32'h1);
    // reset mid-hold
    i1.read = 1; tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("m1_rst_flags", 32'(flags[1]), 32'h0);
    check_eq("m1_rst_nbrd",  32'(nbrd[1]),  32'h0);
    check_eq("m1_rst_fev",   32'(fev[1]),   32'h0);
    i1.read = 0;
    tick();
    rst = 1'b1;
    tick(); tick();
    check_eq("m1_release_flags", 32'(flags[1]), 32'h0);

    // Saturation of the write counter, then clear racing a conflict
    i0.address = 8'h00; i0.write = 1; i0.waitrequest = 0;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    check_eq("sat_nbwr",  32'(nbwr[0]),  32'hFFFF);
    check_eq("sat_flags", 32'(flags[0]), 32'h0);
    clr[0] = 1; i0.read = 1;
    tick();
    check_eq("clr_pulse", 32'(pulse[0]), 32'h01);
    check_eq("clr_flags", 32'(flags[0]), 32'h0);
    check_eq("clr_nbwr",  32'(nbwr[0]),  32'h0);
    check_eq("clr_fev",   32'(fev[0]),   32'h0);
    clr[0] = 0; i0.read = 0; i0.write = 0;
    tick();
    check_eq("post_clr_flags", 32'(flags[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_protocol_monitor.md
Name: avalon_protocol_monitor

Overview:
- Synthesisable Avalon-MM slave-side protocol monitor. Successor to the bench-only assertion checker.
- Covers all five AVALONMODE flavours (waitrequest, fixed wait, pipeline variable, pipeline fixed, burst) with real checking hardware: outstanding-read tracking, latency shift register, burst beat counter.
- Reports through sticky error flags, per-cycle error pulses, a first-error capture and saturating traffic counters.
- Sits passively on the bus beside the DUT, in simulation and on FPGA.

Parameters:
AVALONMODE, 0, 0=waitrequest 1=fixed wait 2=pipeline variable 3=pipeline fixed 4=burst
NBDATABYTES, 2, data bytes; data width 8*NBDATABYTES
NBADDRBITS, 8, address width
WRITEDELAY, 2, mode 1 required write hold cycles (1..15)
READDELAY, 1, mode 1 required read hold cycles (1..15)
FIXEDDELAY, 2, mode 3 read latency in cycles (1..16)
MAXPENDING, 8, max outstanding read beats (1..255)
MAXBURST, 8, max legal burstcount (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
address  in  NBADDRBITS  bus address
byteenable  in  NBDATABYTES  byte enables
readdata  in  8*NBDATABYTES  monitored only
writedata  in  8*NBDATABYTES  write data
read  in  1  read request
write  in  1  write request
waitrequest  in  1  slave stall
readdatavalid  in  1  read data valid
burstcount  in  8  burst length
beginbursttransfer  in  1  burst start marker
err_clear  in  1  sync clear of err_flags, first_err*, counters
err_flags  out  8  sticky error bits
err_pulse  out  8  errors detected this cycle
first_err  out  3  index of first error since clear
first_err_valid  out  1  first_err holds a value
pending_cnt  out  8  outstanding read beats
nb_read_cmd  out  16  accepted reads, saturating
nb_write_cmd  out  16  accepted write beats, saturating
nb_rdv  out  16  readdatavalid beats, saturating

Behaviour:
- rst low: all outputs and internal state 0, immediately. Mid-burst or mid-latency state is discarded.
- All outputs registered. A violation sampled at edge k appears on err_pulse after edge k. err_pulse is 1 cycle wide. err_flags |= err_pulse.
- Accept = (read|write) & !waitrequest. In mode 1, waitrequest is ignored: accept is the last cycle of the hold.
- bit0 RW_CONFLICT: read & write, any mode.
- bit1 UNSTABLE:
  - Condition: previous cycle had (read|write) & waitrequest, and any of address, byteenable, read, write, burstcount changed (or writedata, if write).
  - Applies in modes 0, 2, 3, 4.
- bit2 RDV_UNDERFLOW: readdatavalid with pending_cnt==0 and no same-cycle increment. Modes 2–4. pending_cnt stays 0.
- bit3 PENDING_OVERFLOW:
  - Condition: an accepted read would push pending_cnt above MAXPENDING.
  - pending_cnt saturates at 255.
- pending_cnt next = pending_cnt + inc − dec.
  - inc = 1 on read accept (modes 2, 3), or burstcount (mode 4).
  - dec = readdatavalid.
  - Simultaneous inc and dec net out.
- bit4 FIXED_LATENCY, mode 3 only:
  - A FIXEDDELAY-deep shift register carries read accepts.
  - Error when its output differs from readdatavalid (missing or extra beat).
- bit5 BURST_FORMAT, mode 4 only. Any of:
  - burstcount==0 or >MAXBURST at first beat;
  - beginbursttransfer without read|write;
  - a read while a write burst is open;
  - burstcount or address changed between beats of an open write burst.
- Write burst state machine, mode 4:
  - IDLE→WBURST on accepted write with burstcount>1, loading remaining=burstcount−1.
  - In WBURST, each accepted write decrements remaining. remaining 0 → IDLE.
  - Reset or err_clear → IDLE.
- bit6 reserved, 0.
- bit7 FIXED_WAIT, mode 1 only:
  - Hold counter counts consecutive read (or write) cycles.
  - Error if the strobe drops before READDELAY (WRITEDELAY) cycles.
  - Counter clears when the strobe drops.
- first_err: lowest set bit of the first nonzero err_pulse after reset or clear. Latched until the next clear.
- err_clear has priority over a same-cycle detection: flags clear, and the new pulse is still shown on err_pulse but not latched.
- Counters saturate at 16'hFFFF and do not wrap.

Test Plan:
- Mode 0: read with waitrequest high 3 cycles, address 8'h10 held, accept → err_flags=0, nb_read_cmd=1. Repeat with address changed to 8'h11 in cycle 2 → err_pulse[1] for 1 cycle, first_err=1.
- Mode 2: 3 back-to-back read accepts, then 3 readdatavalid → pending_cnt 1,2,3,2,1,0. Fourth readdatavalid → err_flags[2]=1, pending_cnt=0.
- Mode 3, FIXEDDELAY=2: read accepted at cycle 5, readdatavalid at cycle 7 → no error. readdatavalid at cycle 8 instead → err_pulse[4] at cycles 7 and 8.
- Mode 4, MAXBURST=8: write burstcount=4, 4 accepted beats → burst FSM returns to IDLE, nb_write_cmd=4. burstcount=9 → err_flags[5]. Read during open burst → err_flags[5].
- Mode 1, READDELAY=3: read held 2 cycles → err_flags[7]=1. Then assert rst low mid-hold → all outputs 0 same cycle, no error on release.
- Saturation/clear: 70000 write accepts → nb_write_cmd=16'hFFFF. err_clear with simultaneous read&write → err_pulse[0]=1, err_flags=0, nb_write_cmd=0.
